fb_dac_output_stage: RTL and testbench
======================================

// Module: fb_dac_output_stage
// PURPOSE
//  Feedback DAC output stage, directly downstream of the DSP calc module. Captures the 15-bit
//  feedback result (pout) on the fb_cond window, adds a static trim offset, saturates to DAC width,
//  and drives offset-binary data plus a write strobe timed by the upstream dac_clk window.
//  Holds each kick for a programmed time, then returns to mid-scale; saturating diagnostic counters.
// PARAMETERS
//  DAC_W        13   DAC data width (two's-complement internal range -2^(DAC_W-1)..2^(DAC_W-1)-1)
//  HOLD_CYCLES  16   cycles dac_data is held after dac_wr deasserts (>=1)
//  TIMEOUT      32   max cycles in LOADED waiting for dac_clk rising edge
//  KILL_OFLOW   1    1: a captured DSPoflow forces the kick to code 0 (mid-scale)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  pout         in   15     signed feedback result from DSP calc
//  DSPoflow     in   1      DSP accumulator overflow flag, valid with pout
//  fb_cond      in   1      2-cycle capture window from DSP calc
//  dac_clk      in   1      2-cycle DAC write window from DSP calc
//  store_strb   in   1      store enable; low = abort to IDLE
//  fb_en        in   1      feedback enable; gates new captures only
//  offset       in   13     signed trim added to pout
//  cnt_clr      in   1      synchronous clear of all counters and overrun
//  dac_data     out  DAC_W  offset-binary DAC code (MSB inverted)
//  dac_wr       out  1      DAC write strobe
//  sat          out  1      last captured kick saturated
//  overrun      out  1      sticky: fb_cond rise seen while not IDLE
//  sat_cnt      out  8      saturations, saturating at 255
//  oflow_cnt    out  8      captured DSPoflow events, saturating at 255
//  tout_cnt     out  8      LOADED timeouts, saturating at 255
// BEHAVIOUR
//  Reset: state=IDLE, dac_data=mid-scale (1<<(DAC_W-1), 13'h1000), dac_wr=0, sat=0, overrun=0,
//   all counters 0. Edge detectors (fb_cond_d, dac_clk_d) reset to 0.
//  fb_rise = fb_cond & ~fb_cond_d; dac_rise = dac_clk & ~dac_clk_d.
//  Arithmetic: sum = sext16(pout)+sext16(offset); clamp to [-2^(DAC_W-1), 2^(DAC_W-1)-1]; sat=1
//   if clamped. If KILL_OFLOW and captured DSPoflow: code=0, sat=0. Output = {~code[MSB],code[rest]}.
//  FSM:
//   IDLE: fb_rise & fb_en & store_strb -> CALC; register sum and DSPoflow in that cycle (N).
//   CALC: (cycle N+1) register clamped code, sat; bump sat_cnt/oflow_cnt -> LOADED.
//   LOADED: dac_rise -> DRIVE, dac_data=code and dac_wr=1 from next cycle;
//    TIMEOUT cycles without dac_rise -> IDLE, tout_cnt++, dac_data unchanged (mid-scale).
//   DRIVE: dac_wr=1 exactly 2 cycles, then 0 -> HOLD.
//   HOLD: dac_data held HOLD_CYCLES cycles, then dac_data=mid-scale -> IDLE.
//  fb_rise in any state other than IDLE: ignored, overrun<=1 (sticky).
//  store_strb=0: next edge state=IDLE, dac_wr=0, dac_data=mid-scale, regardless of state;
//   takes priority over all transitions. fb_en=0 only blocks IDLE->CALC.
//  cnt_clr has priority over same-cycle increment; counters hold at 255.
//  rst mid-operation: immediate return to reset values, no partial write strobe.
// TESTING
//  pout=1000, offset=-8, fb window then dac window -> dac_data=13'h13E0 for HOLD_CYCLES+2 cycles,
//   dac_wr high 2 cycles starting 1 cycle after dac_clk rise, then 13'h1000.
//  pout=16383, offset=100 -> code 4095, dac_data=13'h1FFF, sat=1, sat_cnt=1;
//   pout=-16384 -> dac_data=13'h0000, sat_cnt=2.
//  DSPoflow=1 at capture, pout=500 -> dac_data=13'h1000, oflow_cnt=1, dac_wr still pulses.
//  fb window with no dac_clk -> IDLE after TIMEOUT=32 cycles, tout_cnt=1, dac_wr never asserted.
//  second fb_cond rise during HOLD -> overrun=1, kick unchanged; cnt_clr -> overrun=0, counters 0.
//  store_strb low during DRIVE -> next cycle dac_wr=0, dac_data=13'h1000, state IDLE; async rst
//   mid-HOLD -> outputs at reset values without waiting for clk.

Source files
------------

// File: rtl/fb_dac_output_stage.sv
// Feedback DAC output stage: captures the DSP kick, trims, saturates,
// strobes it into the DAC, holds it, then returns to mid-scale.
module fb_dac_output_stage #(
  parameter int DAC_W       = 13,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 32,
  parameter int KILL_OFLOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      pout,
  input  logic             DSPoflow,
  input  logic             fb_cond,
  input  logic             dac_clk,
  input  logic             store_strb,
  input  logic             fb_en,
  input  logic [12:0]      offset,
  input  logic             cnt_clr,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_wr,
  output logic             sat,
  output logic             overrun,
  output logic [7:0]       sat_cnt,
  output logic [7:0]       oflow_cnt,
  output logic [7:0]       tout_cnt
);

  typedef enum logic [2:0] {
    IDLE, CALC, LOADED, DRIVE, HOLD
  } state_t;

  localparam int TMAX =
    (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic signed [15:0] MAXV =
    16'((1 << (DAC_W - 1)) - 1);
  localparam logic signed [15:0] MINV = -MAXV - 16'sd1;
  localparam logic [DAC_W-1:0] MID =
    {1'b1, {(DAC_W-1){1'b0}}};

  state_t state_q, n_state;
  logic [TW-1:0] timer_q, n_timer;
  logic signed [15:0] sum_q, n_sum, sum_in;
  logic ofl_q, n_ofl;
  logic [DAC_W-1:0] code_q, n_code, code_c;
  logic [DAC_W-1:0] data_q, n_data;
  logic sat_q, n_sat, clip;
  logic wr_q, n_wr;
  logic ovr_q, n_ovr;
  logic [7:0] satc_q, n_satc;
  logic [7:0] oflc_q, n_oflc;
  logic [7:0] toc_q, n_toc;
  logic fb_d, dc_d;
  logic fb_rise, dac_rise;

  function automatic logic [7:0] inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign fb_rise  = fb_cond & ~fb_d;
  assign dac_rise = dac_clk & ~dc_d;
  assign sum_in   = {pout[14], pout} +
                    {{3{offset[12]}}, offset};

  // Kill path forces mid-scale and is not reported as a saturation
  always_comb begin
    clip   = 1'b0;
    code_c = sum_q[DAC_W-1:0];
    if (sum_q > MAXV) begin
      clip   = 1'b1;
      code_c = MAXV[DAC_W-1:0];
    end else if (sum_q < MINV) begin
      clip   = 1'b1;
      code_c = MINV[DAC_W-1:0];
    end
    if (KILL_OFLOW != 0 && ofl_q) begin
      clip   = 1'b0;
      code_c = '0;
    end
  end

  always_comb begin
    n_state = state_q;
    n_timer = timer_q;
    n_sum   = sum_q;
    n_ofl   = ofl_q;
    n_code  = code_q;
    n_sat   = sat_q;
    n_data  = data_q;
    n_wr    = wr_q;
    n_ovr   = ovr_q;
    n_satc  = satc_q;
    n_oflc  = oflc_q;
    n_toc   = toc_q;
    if (fb_rise && state_q != IDLE) n_ovr = 1'b1;
    if (!store_strb) begin
      n_state = IDLE;
      n_timer = '0;
      n_wr    = 1'b0;
      n_data  = MID;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fb_rise && fb_en) begin
            n_state = CALC;
            n_sum   = sum_in;
            n_ofl   = DSPoflow;
          end
        end
        CALC: begin
          n_code  = code_c;
          n_sat   = clip;
          if (clip)  n_satc = inc8(satc_q);
          if (ofl_q) n_oflc = inc8(oflc_q);
          n_state = LOADED;
          n_timer = '0;
        end
        LOADED: begin
          if (dac_rise) begin
            n_state = DRIVE;
            n_data  = {~code_q[DAC_W-1],
                       code_q[DAC_W-2:0]};
            n_wr    = 1'b1;
            n_timer = '0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            n_state = IDLE;
            n_toc   = inc8(toc_q);
            n_timer = '0;
          end else begin
            n_timer = timer_q + 1'b1;
          end
        end
        DRIVE: begin
          if (timer_q == TW'(1)) begin
            n_wr    = 1'b0;
            n_state = HOLD;
            n_timer = '0;
          end else begin
            n_timer = timer_q + 1'b1;
          end
        end
        HOLD: begin
          if (timer_q == TW'(HOLD_CYCLES - 1)) begin
            n_data  = MID;
            n_state = IDLE;
            n_timer = '0;
          end else begin
            n_timer = timer_q + 1'b1;
          end
        end
        default: n_state = IDLE;
      endcase
    end
    if (cnt_clr) begin
      n_satc = '0;
      n_oflc = '0;
      n_toc  = '0;
      n_ovr  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      sum_q   <= '0;
      ofl_q   <= 1'b0;
      code_q  <= '0;
      sat_q   <= 1'b0;
      data_q  <= MID;
      wr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      satc_q  <= '0;
      oflc_q  <= '0;
      toc_q   <= '0;
      fb_d    <= 1'b0;
      dc_d    <= 1'b0;
    end else begin
      state_q <= n_state;
      timer_q <= n_timer;
      sum_q   <= n_sum;
      ofl_q   <= n_ofl;
      code_q  <= n_code;
      sat_q   <= n_sat;
      data_q  <= n_data;
      wr_q    <= n_wr;
      ovr_q   <= n_ovr;
      satc_q  <= n_satc;
      oflc_q  <= n_oflc;
      toc_q   <= n_toc;
      fb_d    <= fb_cond;
      dc_d    <= dac_clk;
    end
  end

  assign dac_data  = data_q;
  assign dac_wr    = wr_q;
  assign sat       = sat_q;
  assign overrun   = ovr_q;
  assign sat_cnt   = satc_q;
  assign oflow_cnt = oflc_q;
  assign tout_cnt  = toc_q;

endmodule

// File: tb/tb_fb_dac_output_stage.sv
// Directed bench for fb_dac_output_stage with hand-computed
// DAC codes, strobe timing, counters and abort/reset behaviour.
module tb_fb_dac_output_stage;

  logic clk, rst;
  logic signed [14:0] pout;
  logic DSPoflow, fb_cond, dac_clk;
  logic store_strb, fb_en, cnt_clr;
  logic signed [12:0] offset;
  logic [12:0] dac_data;
  logic dac_wr, sat, overrun;
  logic [7:0] sat_cnt, oflow_cnt, tout_cnt;

  int total = 0;
  int bad = 0;

  localparam logic [12:0] MID = 13'h1000;

  fb_dac_output_stage dut (
    .clk(clk), .rst(rst), .pout(pout),
    .DSPoflow(DSPoflow), .fb_cond(fb_cond),
    .dac_clk(dac_clk), .store_strb(store_strb),
    .fb_en(fb_en), .offset(offset),
    .cnt_clr(cnt_clr), .dac_data(dac_data),
    .dac_wr(dac_wr), .sat(sat), .overrun(overrun),
    .sat_cnt(sat_cnt), .oflow_cnt(oflow_cnt),
    .tout_cnt(tout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input logic signed [14:0] p,
                      input logic signed [12:0] off,
                      input logic ofl);
    pout     = p;
    offset   = off;
    DSPoflow = ofl;
    fb_cond  = 1'b1;
    tick();
    tick();
    fb_cond  = 1'b0;
    DSPoflow = 1'b0;
  endtask

  task automatic run_kick(input logic signed [14:0] p,
                          input logic signed [12:0] off,
                          input logic ofl,
                          input logic [12:0] exp,
                          input logic ovr);
    load(p, off, ofl);
    dac_clk = 1'b1;
    tick();
    chk("wr_c1", 32'(dac_wr), 32'd1);
    chk("data_c1", 32'(dac_data), 32'(exp));
    tick();
    chk("wr_c2", 32'(dac_wr), 32'd1);
    dac_clk = 1'b0;
    tick();
    chk("wr_off", 32'(dac_wr), 32'd0);
    chk("data_c3", 32'(dac_data), 32'(exp));
    for (int i = 0; i < 15; i++) begin
      if (ovr && i == 2) fb_cond = 1'b1;
      if (ovr && i == 4) fb_cond = 1'b0;
      tick();
      chk("hold_data", 32'(dac_data), 32'(exp));
      chk("hold_wr", 32'(dac_wr), 32'd0);
    end
    tick();
    chk("mid_ret", 32'(dac_data), 32'(MID));
  endtask

  initial begin
    rst = 1'b1;
    pout = '0;
    offset = '0;
    DSPoflow = 1'b0;
    fb_cond = 1'b0;
    dac_clk = 1'b0;
    store_strb = 1'b1;
    fb_en = 1'b1;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_data", 32'(dac_data), 32'(MID));
    chk("rst_wr", 32'(dac_wr), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_cnts", {8'd0, sat_cnt, oflow_cnt, tout_cnt},
        32'd0);
    rst = 1'b0;
    tick();

    run_kick(15'sd1000, -13'sd8, 1'b0, 13'h13E0, 1'b0);
    chk("k1_sat", 32'(sat), 32'd0);

    run_kick(15'sd16383, 13'sd100, 1'b0, 13'h1FFF, 1'b0);
    chk("pos_sat", 32'(sat), 32'd1);
    chk("pos_satcnt", 32'(sat_cnt), 32'd1);

    run_kick(-15'sd16384, 13'sd100, 1'b0, 13'h0000, 1'b0);
    chk("neg_sat", 32'(sat), 32'd1);
    chk("neg_satcnt", 32'(sat_cnt), 32'd2);

    run_kick(15'sd500, 13'sd0, 1'b1, 13'h1000, 1'b0);
    chk("ofl_cnt", 32'(oflow_cnt), 32'd1);
    chk("ofl_sat", 32'(sat), 32'd0);
    chk("ofl_satcnt", 32'(sat_cnt), 32'd2);

    load(15'sd1000, -13'sd8, 1'b0);
    for (int i = 0; i < 31; i++) begin
      tick();
      chk("to_wr", 32'(dac_wr), 32'd0);
      chk("to_data", 32'(dac_data), 32'(MID));
    end
    chk("to_early", 32'(tout_cnt), 32'd0);
    tick();
    chk("to_cnt", 32'(tout_cnt), 32'd1);
    chk("to_wr_end", 32'(dac_wr), 32'd0);

    run_kick(15'sd1000, -13'sd8, 1'b0, 13'h13E0, 1'b0);

    fb_en = 1'b0;
    load(15'sd1000, -13'sd8, 1'b0);
    dac_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fben_wr", 32'(dac_wr), 32'd0);
      chk("fben_data", 32'(dac_data), 32'(MID));
    end
    dac_clk = 1'b0;
    fb_en = 1'b1;
    tick();
    chk("fben_ovr", 32'(overrun), 32'd0);

    run_kick(15'sd1000, -13'sd8, 1'b0, 13'h13E0, 1'b1);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_satcnt", 32'(sat_cnt), 32'd2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    chk("clr_cnts", {8'd0, sat_cnt, oflow_cnt, tout_cnt},
        32'd0);

    for (int i = 0; i < 256; i++)
      run_kick(15'sd16383, 13'sd100, 1'b0, 13'h1FFF, 1'b0);
    chk("satcnt_max", 32'(sat_cnt), 32'd255);

    load(15'sd1000, -13'sd8, 1'b0);
    dac_clk = 1'b1;
    tick();
    chk("ab_wr_pre", 32'(dac_wr), 32'd1);
    store_strb = 1'b0;
    tick();
    chk("ab_wr", 32'(dac_wr), 32'd0);
    chk("ab_data", 32'(dac_data), 32'(MID));
    store_strb = 1'b1;
    dac_clk = 1'b0;
    tick();
    run_kick(15'sd1000, -13'sd8, 1'b0, 13'h13E0, 1'b0);

    load(15'sd16383, 13'sd100, 1'b0);
    dac_clk = 1'b1;
    tick();
    tick();
    dac_clk = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst", 32'(dac_data), 32'h1FFF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(dac_data), 32'(MID));
    chk("arst_wr", 32'(dac_wr), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    chk("arst_satcnt", 32'(sat_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_kick(15'sd16383, 13'sd100, 1'b0, 13'h1FFF, 1'b0);
    chk("post_satcnt", 32'(sat_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
